// File: rtl/score_bcd_display.sv
// rtl/score_bcd_display.sv - frame-paced score to BCD converter with high-score tracking
//
// Purpose: once per frame, convert either the live score (play screen) or the
// session high score (any other screen) into four BCD digits. The conversion is
// a sequential double-dabble, one bit per clock. The block also tracks the best
// final score and flags new records.
//
// Ports:
//   clk          rising-edge system clock
//   reset        synchronous active-high reset
//   startOfFrame one-cycle frame pulse; requests a conversion if the value changed
//   score        current game score
//   currScreen   0 start, 1 play, 2 over, 3 win
//   digit0..3    BCD units, tens, hundreds, thousands
//   digit_blank  bit i set means digit i is a leading zero (bit 0 never set)
//   bcd_valid    one-cycle pulse when the digits update
//   busy         high while a conversion is in progress
//   high_score   best final score since reset
//   new_record   one-cycle pulse when high_score is raised
module score_bcd_display #(
    parameter int          SCORE_W     = 13,
    parameter int          NUM_DIGITS  = 4,
    parameter logic [1:0]  PLAY_SCREEN = 2'd1,
    parameter logic [1:0]  OVER_SCREEN = 2'd2,
    parameter logic [1:0]  WIN_SCREEN  = 2'd3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  startOfFrame,
    input  logic [SCORE_W-1:0]    score,
    input  logic [1:0]            currScreen,
    output logic [3:0]            digit0,
    output logic [3:0]            digit1,
    output logic [3:0]            digit2,
    output logic [3:0]            digit3,
    output logic [NUM_DIGITS-1:0] digit_blank,
    output logic                  bcd_valid,
    output logic                  busy,
    output logic [SCORE_W-1:0]    high_score,
    output logic                  new_record
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int SR_W  = BCD_W + SCORE_W;
    localparam int CNT_W = $clog2(SCORE_W);

    localparam logic [CNT_W-1:0]      LAST_ITER   = CNT_W'(SCORE_W - 1);
    localparam logic [NUM_DIGITS-1:0] BLANK_RESET = {{(NUM_DIGITS-1){1'b1}}, 1'b0};

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [SR_W-1:0]       shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    logic [SCORE_W-1:0]    last_q, last_d;
    logic [SCORE_W-1:0]    high_q;
    logic                  record_q;
    logic [1:0]            prev_screen_q;

    logic [SCORE_W-1:0]    sel_value;
    logic [SR_W-1:0]       adj;
    logic [SR_W-1:0]       shifted;
    logic [BCD_W-1:0]      bcd_next;
    logic [NUM_DIGITS-1:0] blank_next;

    // The high score shown here is the registered value, so a record set on the
    // same edge as a frame sample is picked up by the following frame.
    assign sel_value = (currScreen == PLAY_SCREEN) ? score : high_q;

    // One double-dabble step: correct every BCD nibble, then shift.
    always_comb begin
        adj = shift_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (adj[SCORE_W+4*i +: 4] >= 4'd5) begin
                adj[SCORE_W+4*i +: 4] = adj[SCORE_W+4*i +: 4] + 4'd3;
            end
        end
        shifted  = adj << 1;
        bcd_next = shifted[SR_W-1:SCORE_W];

        blank_next                 = '0;
        blank_next[NUM_DIGITS-1]   = (bcd_next[BCD_W-1 -: 4] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 1; i--) begin
            blank_next[i] = blank_next[i+1] && (bcd_next[4*i +: 4] == 4'd0);
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        bcd_d   = bcd_q;
        blank_d = blank_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (startOfFrame && (sel_value != last_q)) begin
                    shift_d = {{BCD_W{1'b0}}, sel_value};
                    last_d  = sel_value;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            default: begin
                // Frame pulses arriving here are dropped; the next frame re-samples.
                shift_d = shifted;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    bcd_d   = bcd_next;
                    blank_d = blank_next;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            bcd_q   <= '0;
            blank_q <= BLANK_RESET;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            bcd_q   <= bcd_d;
            blank_q <= blank_d;
            last_q  <= last_d;
        end
    end

    // A game ends on the play -> over/win transition; only a strictly higher
    // score counts as a record.
    always_ff @(posedge clk) begin
        if (reset) begin
            high_q        <= '0;
            record_q      <= 1'b0;
            prev_screen_q <= 2'd0;
        end else begin
            prev_screen_q <= currScreen;
            record_q      <= 1'b0;
            if ((prev_screen_q == PLAY_SCREEN) &&
                ((currScreen == OVER_SCREEN) || (currScreen == WIN_SCREEN)) &&
                (score > high_q)) begin
                high_q   <= score;
                record_q <= 1'b1;
            end
        end
    end

    assign digit0      = bcd_q[3:0];
    assign digit1      = bcd_q[7:4];
    assign digit2      = bcd_q[11:8];
    assign digit3      = bcd_q[15:12];
    assign digit_blank = blank_q;
    assign bcd_valid   = valid_q;
    assign busy        = busy_q;
    assign high_score  = high_q;
    assign new_record  = record_q;

endmodule

// File: tb/tb_score_bcd_display.sv
// tb/tb_score_bcd_display.sv - self-checking bench for score_bcd_display
module tb_score_bcd_display;

    logic        clk = 1'b0;
    logic        reset;
    logic        startOfFrame;
    logic [12:0] score;
    logic [1:0]  currScreen;
    logic [3:0]  digit0, digit1, digit2, digit3;
    logic [3:0]  digit_blank;
    logic        bcd_valid;
    logic        busy;
    logic [12:0] high_score;
    logic        new_record;

    int checks = 0;
    int errors = 0;
    int m_last = 0;
    int m_high = 0;

    score_bcd_display dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .score        (score),
        .currScreen   (currScreen),
        .digit0       (digit0),
        .digit1       (digit1),
        .digit2       (digit2),
        .digit3       (digit3),
        .digit_blank  (digit_blank),
        .bcd_valid    (bcd_valid),
        .busy         (busy),
        .high_score   (high_score),
        .new_record   (new_record)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_digits(input int v);
        exp_digits = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] exp_blank(input int v);
        logic [3:0] b;
        b    = 4'b0000;
        b[3] = (v < 1000);
        b[2] = (v < 100);
        b[1] = (v < 10);
        exp_blank = b;
    endfunction

    task automatic pulse_sof();
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    // Expects a conversion of v to start on the next frame pulse.
    task automatic run_conv(input int v, input string name);
        int n;
        pulse_sof();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_start got %0b want 1", name, busy);
        end
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (bcd_valid === 1'b1) break;
        end
        checks++;
        if (n !== 13) begin
            errors++;
            $display("FAIL %s latency got %0d want 13", name, n);
        end
        checks++;
        if ({digit3, digit2, digit1, digit0} !== exp_digits(v) || digit_blank !== exp_blank(v)) begin
            errors++;
            $display("FAIL %s digits got %h blank %b want %h blank %b", name,
                     {digit3, digit2, digit1, digit0}, digit_blank, exp_digits(v), exp_blank(v));
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_end got %0b want 0", name, busy);
        end
        @(negedge clk);
        checks++;
        if (bcd_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s valid_width got %0b want 0", name, bcd_valid);
        end
        m_last = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_last = 0;
        m_high = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({digit3, digit2, digit1, digit0} !== 16'h0000 || digit_blank !== 4'b1110 ||
            bcd_valid !== 1'b0 || busy !== 1'b0 || high_score !== 13'd0 || new_record !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got d=%h b=%b v=%0b bz=%0b hs=%0d nr=%0b want d=0000 b=1110 v=0 bz=0 hs=0 nr=0",
                     {digit3, digit2, digit1, digit0}, digit_blank, bcd_valid, busy, high_score, new_record);
        end
    endtask

    task automatic test_no_conv_zero();
        int seen;
        currScreen = 2'd1;
        score      = 13'd0;
        pulse_sof();
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            if (busy === 1'b1 || bcd_valid === 1'b1) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0 || digit_blank !== 4'b1110 || {digit3, digit2, digit1, digit0} !== 16'h0000) begin
            errors++;
            $display("FAIL no_conv_zero activity %0d blank %b got d=%h want 0 1110 0000", seen, digit_blank,
                     {digit3, digit2, digit1, digit0});
        end
    endtask

    task automatic test_directed();
        int vals[4] = '{1234, 8191, 45, 7};
        currScreen = 2'd1;
        foreach (vals[i]) begin
            score = 13'(vals[i]);
            run_conv(vals[i], $sformatf("directed_%0d", vals[i]));
        end
    endtask

    task automatic test_high_score();
        currScreen = 2'd1;
        score      = 13'd100;
        @(negedge clk);
        currScreen = 2'd2;
        @(negedge clk);
        if (100 > m_high) m_high = 100;
        checks++;
        if (high_score !== 13'(m_high) || new_record !== 1'b1) begin
            errors++;
            $display("FAIL high_update got hs=%0d nr=%0b want hs=%0d nr=1", high_score, new_record, m_high);
        end
        @(negedge clk);
        checks++;
        if (new_record !== 1'b0) begin
            errors++;
            $display("FAIL record_width got %0b want 0", new_record);
        end
        score = 13'd3;
        run_conv(m_high, "over_shows_high");
        currScreen = 2'd1;
        score      = 13'd100;
        @(negedge clk);
        currScreen = 2'd3;
        @(negedge clk);
        checks++;
        if (high_score !== 13'd100 || new_record !== 1'b0) begin
            errors++;
            $display("FAIL equal_no_update got hs=%0d nr=%0b want hs=100 nr=0", high_score, new_record);
        end
        currScreen = 2'd1;
        score      = 13'd40;
        @(negedge clk);
        currScreen = 2'd2;
        @(negedge clk);
        checks++;
        if (high_score !== 13'd100 || new_record !== 1'b0) begin
            errors++;
            $display("FAIL lower_no_update got hs=%0d nr=%0b want hs=100 nr=0", high_score, new_record);
        end
        currScreen = 2'd1;
        @(negedge clk);
    endtask

    task automatic test_ignore_mid_conv();
        int n;
        currScreen = 2'd1;
        score      = 13'd999;
        pulse_sof();
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (n == 5) begin
                score        = 13'd500;
                startOfFrame = 1'b1;
            end else begin
                startOfFrame = 1'b0;
            end
            if (bcd_valid === 1'b1) break;
        end
        startOfFrame = 1'b0;
        checks++;
        if (n !== 13 || {digit3, digit2, digit1, digit0} !== 16'h0999) begin
            errors++;
            $display("FAIL ignore_mid_conv got n=%0d d=%h want n=13 d=0999", n, {digit3, digit2, digit1, digit0});
        end
        @(negedge clk);
        m_last = 999;
        run_conv(500, "after_ignored_500");
    endtask

    task automatic test_random();
        int v;
        currScreen = 2'd1;
        for (int k = 0; k < 8; k++) begin
            v = int'($urandom_range(0, 8191));
            if (v == m_last) v = (v + 1) % 8192;
            score = 13'(v);
            run_conv(v, $sformatf("random_%0d", v));
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        currScreen = 2'd1;
        score      = (m_last == 4321) ? 13'd4322 : 13'd4321;
        pulse_sof();
        for (int i = 0; i < 5; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_last = 0;
        m_high = 0;
        checks++;
        if (busy !== 1'b0 || bcd_valid !== 1'b0 || {digit3, digit2, digit1, digit0} !== 16'h0000 ||
            digit_blank !== 4'b1110 || high_score !== 13'd0) begin
            errors++;
            $display("FAIL reset_abort got bz=%0b v=%0b d=%h b=%b hs=%0d want 0 0 0000 1110 0",
                     busy, bcd_valid, {digit3, digit2, digit1, digit0}, digit_blank, high_score);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bcd_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_valid got %0d pulses want 0", seen);
        end
    endtask

    initial begin
        reset        = 1'b1;
        startOfFrame = 1'b0;
        score        = 13'd0;
        currScreen   = 2'd0;
        @(negedge clk);
        test_reset();
        test_no_conv_zero();
        test_directed();
        test_high_score();
        test_ignore_mid_conv();
        test_random();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
